// File: rtl/jt10_adpcm_rom.sv
// jt10_adpcm_rom
//   ADPCM-A sample ROM responder. It sits between the ADPCM-A address
//   counter and the external sample memory. Each channel keeps a one-byte
//   cache. The counter's time-multiplexed nibble reads are answered from
//   that cache. A read that misses the cache is fetched through a single
//   outstanding request/acknowledge memory port.
//
//   Optional feature macro: JT10_ADPCM_PREFETCH_EN.
//     When it is defined, a hit or bypass with sel=1 consumes the low nibble
//     of the cached byte, so the following byte is requested straight away.
//
// Ports
//   clk, rst_n          clock and synchronous active-low reset
//   cen                 channel-slot enable, one slot per pulse
//   cur_ch[CH-1:0]      one-hot channel owning the current slot
//   addr[19:0], bank    byte address {bank,addr} requested by the counter
//   sel                 0 selects byte[7:4], 1 selects byte[3:0]
//   roe_n               active-low read strobe, qualified by cen
//   clr                 restart of the slot channel; drops its cache/fetch
//   mem_addr, mem_rd    fetch address and request, held until mem_ok
//   mem_ok, mem_data    single-cycle return strobe and the fetched byte
//   dout                registered nibble for the decoder
//   underrun            one-cycle pulse when the slot read missed the cache
module jt10_adpcm_rom #(
  parameter int CH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [CH-1:0] cur_ch,
  input  logic [19:0]   addr,
  input  logic [3:0]    bank,
  input  logic          sel,
  input  logic          roe_n,
  input  logic          clr,
  output logic [23:0]   mem_addr,
  output logic          mem_rd,
  input  logic          mem_ok,
  input  logic [7:0]    mem_data,
  output logic [3:0]    dout,
  output logic          underrun
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nx;
  logic [23:0]   tag  [CH];
  logic [7:0]    data [CH];
  logic [CH-1:0] valid, pend;
  logic [IW-1:0] req_idx, rr_ptr;

  logic          slot_act;
  logic [IW-1:0] slot_idx;
  logic [23:0]   slot_a;
  logic          ret, hit, byp;
  logic          grant_ok;
  logic [IW-1:0] grant_idx;

  function automatic logic [3:0] nibble(input logic [7:0] b, input logic s);
    return s ? b[3:0] : b[7:4];
  endfunction

  // Slot decode: one-hot channel to index, and the cache lookup for it
  always_comb begin
    slot_idx = '0;
    for (int i = 0; i < CH; i++)
      if (cur_ch[i]) slot_idx = IW'(i);
  end

  assign slot_act = cen && (cur_ch != '0);
  assign slot_a   = {bank, addr};
  assign ret      = (state == WAIT) && mem_ok;
  assign hit      = valid[slot_idx] && (tag[slot_idx] == slot_a);
  // The byte arriving this cycle is exactly the one being read
  assign byp      = ret && (req_idx == slot_idx) && (mem_addr == slot_a);

  // Round-robin search starting at rr_ptr; scanning backwards so the
  // closest pending channel after the pointer wins.
  always_comb begin
    logic [IW:0]   c;
    logic [IW-1:0] ci;
    grant_ok  = 1'b0;
    grant_idx = rr_ptr;
    c         = '0;
    ci        = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      c = {1'b0, rr_ptr} + (IW+1)'(k);
      if (c >= (IW+1)'(CH)) c = c - (IW+1)'(CH);
      ci = c[IW-1:0];
      if (pend[ci]) begin
        grant_ok  = 1'b1;
        grant_idx = ci;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_ok) state_nx = WAIT;
      WAIT:    if (mem_ok)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Register stage: arbiter, memory return, then slot updates. Slot writes
  // come last so they override a return landing on the same channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      req_idx  <= '0;
      rr_ptr   <= '0;
      valid    <= '0;
      pend     <= '0;
      dout     <= '0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nx;
      underrun <= 1'b0;

      if (state == IDLE && grant_ok) begin
        mem_rd   <= 1'b1;
        mem_addr <= tag[grant_idx];
        req_idx  <= grant_idx;
        rr_ptr   <= (grant_idx == IW'(CH - 1)) ? '0 : grant_idx + 1'b1;
      end

      if (ret) begin
        mem_rd <= 1'b0;
        // A clr or a new miss since the request makes the return stale
        if (pend[req_idx] && tag[req_idx] == mem_addr) begin
          data[req_idx]  <= mem_data;
          valid[req_idx] <= 1'b1;
          pend[req_idx]  <= 1'b0;
        end
      end

      if (slot_act) begin
        if (clr) begin
          valid[slot_idx] <= 1'b0;
          pend[slot_idx]  <= 1'b0;
        end else if (!roe_n) begin
          if (hit || byp) begin
            dout <= nibble(hit ? data[slot_idx] : mem_data, sel);
            if (!hit) begin
              tag[slot_idx]   <= slot_a;
              data[slot_idx]  <= mem_data;
              valid[slot_idx] <= 1'b1;
              pend[slot_idx]  <= 1'b0;
            end
`ifdef JT10_ADPCM_PREFETCH_EN
            if (sel) begin
              tag[slot_idx]   <= slot_a + 24'd1;
              valid[slot_idx] <= 1'b0;
              pend[slot_idx]  <= 1'b1;
            end
`endif
          end else begin
            tag[slot_idx]   <= slot_a;
            valid[slot_idx] <= 1'b0;
            pend[slot_idx]  <= 1'b1;
            underrun        <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_rom.sv
module tb_jt10_adpcm_rom;

  logic        clk = 1'b0;
  logic        rst_n, cen, sel, roe_n, clr, mem_ok;
  logic [5:0]  cur_ch;
  logic [19:0] addr;
  logic [3:0]  bank;
  logic [7:0]  mem_data;
  logic [23:0] mem_addr;
  logic        mem_rd, underrun;
  logic [3:0]  dout;

  int checks = 0;
  int errors = 0;

  jt10_adpcm_rom #(.CH(6)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cur_ch(cur_ch), .addr(addr),
    .bank(bank), .sel(sel), .roe_n(roe_n), .clr(clr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_ok(mem_ok), .mem_data(mem_data), .dout(dout),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // One channel slot: drive at negedge, return 1 after the slot edge
  task automatic slot(input int ch, input logic [23:0] a, input logic s,
                      input logic rd_n, input logic c);
    @(negedge clk);
    cur_ch = '0;
    cur_ch[ch] = 1'b1;
    {bank, addr} = a;
    sel = s; roe_n = rd_n; clr = c; cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0; roe_n = 1'b1; clr = 1'b0; cur_ch = '0;
  endtask

  task automatic mem_ret(input logic [7:0] d);
    @(negedge clk);
    mem_ok = 1'b1; mem_data = d;
    @(posedge clk); #1;
    mem_ok = 1'b0;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cen = 1'b0; cur_ch = '0; addr = '0; bank = '0;
    sel = 1'b0; roe_n = 1'b1; clr = 1'b0; mem_ok = 1'b0; mem_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout !== 4'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_miss_fill;
    bit ok;
    slot(0, 24'h012345, 1'b0, 1'b0, 1'b0);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL miss_underrun got=%b exp=1", underrun); end
    @(posedge clk); #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 24'h012345) begin errors++; $display("FAIL miss_req rd=%b addr=%h exp rd=1 addr=012345", mem_rd, mem_addr); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pulse got=%b exp=0", underrun); end
    mem_ret(8'hA7);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rd_drop got=%b exp=0", mem_rd); end
    slot(0, 24'h012345, 1'b0, 1'b0, 1'b0);
    checks++; if (dout !== 4'hA || underrun !== 1'b0) begin errors++; $display("FAIL hit_hi dout=%h und=%b exp A/0", dout, underrun); end
    slot(0, 24'h012345, 1'b1, 1'b0, 1'b0);
    checks++; if (dout !== 4'h7 || underrun !== 1'b0) begin errors++; $display("FAIL hit_lo dout=%h und=%b exp 7/0", dout, underrun); end
`ifndef JT10_ADPCM_PREFETCH_EN
    slot(0, 24'h012346, 1'b0, 1'b0, 1'b0);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL next_byte_underrun got=%b exp=1", underrun); end
`endif
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h012346) begin errors++; $display("FAIL next_byte_req ok=%b addr=%h exp 012346", ok, mem_addr); end
    mem_ret(8'h3C);
    slot(0, 24'h012346, 1'b0, 1'b0, 1'b0);
    checks++; if (dout !== 4'h3 || underrun !== 1'b0) begin errors++; $display("FAIL next_byte_hit dout=%h und=%b exp 3/0", dout, underrun); end
  endtask

  task automatic test_prefetch;
    bit ok;
    bit seen;
    slot(2, 24'h000100, 1'b0, 1'b0, 1'b0);
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h000100) begin errors++; $display("FAIL pf_fill_req ok=%b addr=%h exp 000100", ok, mem_addr); end
    mem_ret(8'h5E);
    slot(2, 24'h000100, 1'b1, 1'b0, 1'b0);
    checks++; if (dout !== 4'hE) begin errors++; $display("FAIL pf_lo dout=%h exp E", dout); end
`ifdef JT10_ADPCM_PREFETCH_EN
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h000101) begin errors++; $display("FAIL pf_req ok=%b addr=%h exp 000101", ok, mem_addr); end
    mem_ret(8'h91);
    slot(2, 24'h000101, 1'b0, 1'b0, 1'b0);
    checks++; if (dout !== 4'h9 || underrun !== 1'b0) begin errors++; $display("FAIL pf_hit dout=%h und=%b exp 9/0", dout, underrun); end
`else
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= mem_rd; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL no_pf_req got rd=%b exp 0", seen); end
`endif
  endtask

  task automatic test_round_robin;
    bit ok;
    slot(1, 24'h100010, 1'b0, 1'b0, 1'b0);
    slot(3, 24'h300030, 1'b0, 1'b0, 1'b0);
    slot(5, 24'h500050, 1'b0, 1'b0, 1'b0);
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h100010) begin errors++; $display("FAIL rr_first ok=%b addr=%h exp 100010", ok, mem_addr); end
    mem_ret(8'h11);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rr_gap1 rd=%b exp 0", mem_rd); end
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h300030) begin errors++; $display("FAIL rr_second ok=%b addr=%h exp 300030", ok, mem_addr); end
    mem_ret(8'h33);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rr_gap2 rd=%b exp 0", mem_rd); end
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h500050) begin errors++; $display("FAIL rr_third ok=%b addr=%h exp 500050", ok, mem_addr); end
    mem_ret(8'h55);
    slot(3, 24'h300030, 1'b0, 1'b0, 1'b0);
    checks++; if (dout !== 4'h3 || underrun !== 1'b0) begin errors++; $display("FAIL rr_hit dout=%h und=%b exp 3/0", dout, underrun); end
  endtask

  task automatic test_clr_wait;
    bit ok;
    slot(4, 24'h000400, 1'b0, 1'b0, 1'b0);
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h000400) begin errors++; $display("FAIL clr_req ok=%b addr=%h exp 000400", ok, mem_addr); end
    slot(4, 24'h000400, 1'b0, 1'b0, 1'b1);
    mem_ret(8'hCD);
    slot(4, 24'h000400, 1'b0, 1'b0, 1'b0);
    checks++; if (underrun !== 1'b1 || dout !== 4'h3) begin errors++; $display("FAIL clr_discard und=%b dout=%h exp 1/3", underrun, dout); end
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h000400) begin errors++; $display("FAIL clr_refetch ok=%b addr=%h exp 000400", ok, mem_addr); end
    mem_ret(8'hCD);
  endtask

  task automatic test_wrap;
    bit ok;
    bit seen;
    slot(0, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'hFFFFFF) begin errors++; $display("FAIL wrap_fill ok=%b addr=%h exp FFFFFF", ok, mem_addr); end
    mem_ret(8'h42);
    slot(0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0);
    checks++; if (dout !== 4'h2) begin errors++; $display("FAIL wrap_lo dout=%h exp 2", dout); end
`ifdef JT10_ADPCM_PREFETCH_EN
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h000000) begin errors++; $display("FAIL wrap_req ok=%b addr=%h exp 000000", ok, mem_addr); end
    mem_ret(8'h99);
    slot(0, 24'h000000, 1'b0, 1'b0, 1'b0);
    checks++; if (dout !== 4'h9 || underrun !== 1'b0) begin errors++; $display("FAIL wrap_hit dout=%h und=%b exp 9/0", dout, underrun); end
`else
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; seen |= mem_rd; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wrap_no_req rd=%b exp 0", seen); end
`endif
  endtask

  task automatic test_reset_wait;
    bit ok;
    bit seen;
    slot(1, 24'h0ABCDE, 1'b0, 1'b0, 1'b0);
    wait_rd(ok);
    checks++; if (!ok || mem_addr !== 24'h0ABCDE) begin errors++; $display("FAIL rstw_req ok=%b addr=%h exp 0ABCDE", ok, mem_addr); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_rd !== 1'b0 || dout !== 4'h0) begin errors++; $display("FAIL rstw_clear rd=%b dout=%h exp 0/0", mem_rd, dout); end
    @(negedge clk); rst_n = 1'b1;
    mem_ret(8'hEE);
    seen = 1'b0;
    repeat (3) begin seen |= mem_rd; @(posedge clk); #1; end
    checks++; if (seen !== 1'b0 || dout !== 4'h0) begin errors++; $display("FAIL rstw_late rd=%b dout=%h exp 0/0", seen, dout); end
    slot(1, 24'h0ABCDE, 1'b0, 1'b0, 1'b0);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL rstw_miss und=%b exp 1", underrun); end
    wait_rd(ok);
    mem_ret(8'h12);
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_prefetch();
    test_round_robin();
    test_clr_wait();
    test_wrap();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
